// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - uart_state_t : transmitter FSM state encoding
//   - TXDATA_OFS / STATUS_OFS : register byte offsets inside the 8-byte window
//   - ST_* : bit positions inside the STATUS word
//   - pack_status(): assembles the STATUS read word from its fields
package mmio_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;

    localparam logic [2:0] TXDATA_OFS = 3'd0;
    localparam logic [2:0] STATUS_OFS = 3'd4;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;
    localparam int ST_PAR     = 9;

    function automatic logic [31:0] pack_status(
        input logic                fsm_busy,
        input logic                full,
        input logic                empty,
        input logic                ovf,
        input logic [ST_CNT_W-1:0] cnt,
        input logic                par_en
    );
        logic [31:0] word;
        word                           = '0;
        word[ST_BUSY]                  = fsm_busy;
        word[ST_FULL]                  = full;
        word[ST_EMPTY]                 = empty;
        word[ST_OVF]                   = ovf;
        word[ST_CNT_LSB +: ST_CNT_W]   = cnt;
        word[ST_PAR]                   = par_en;
        return word;
    endfunction

endpackage

// File: rtl/mmio_uart_fifo.sv
// mmio_uart_fifo: small synchronous FIFO with first-word fall-through read.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-low reset (empties the FIFO)
//   push   - write wdata; accepted when not full or when a pop happens on the same edge
//   pop    - discard the head entry; ignored when empty
//   wdata  - data to push
//   rdata  - current head entry (valid while !empty)
//   full, empty, count - occupancy flags and entry count (one bit wider than the pointers)
module mmio_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    // Head is read combinationally so the transmitter can load it on the pop edge.
    assign rdata = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers are DEPTH-sized (power of two), so they wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the core data port.
// Window (8 bytes at BASE_ADDR): TXDATA at +0 (write pushes a byte, reads 0),
// STATUS at +4 (busy/full/empty/overflow/count/parity-enabled; writing bit3 clears overflow).
// Bytes are buffered in mmio_uart_fifo and sent 8N1, LSB first, on tx.
// Optional build macro MMIO_UART_PARITY_EN adds an even-parity bit after the data bits.
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-low reset
//   MemWrite  - core store strobe
//   DataAdr   - core data address
//   WriteData - core store data
//   ReadData  - combinational read data, 0 outside the window
//   hit       - combinational window match for the top-level read mux
//   tx        - registered serial output, idle high
//   busy      - FSM not idle or FIFO non-empty
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0200_0010,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        tx,
    output logic        busy
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef MMIO_UART_PARITY_EN
    localparam logic        PARITY_EN = 1'b1;
`else
    localparam logic        PARITY_EN = 1'b0;
`endif

    uart_state_t   state_reg;
    logic [15:0]   baud_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          ovf_reg;
`ifdef MMIO_UART_PARITY_EN
    logic          par_reg;
`endif

    logic          sel_status;
    logic          wr_txdata;
    logic          wr_status;
    logic          baud_last;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status_word;
    logic          unused_bits;

    // Only bits [7:0] (TXDATA) and bit 3 (STATUS) of the store data matter,
    // and the two lowest address bits are ignored inside the window.
    assign unused_bits = &{1'b0, WriteData[31:8], DataAdr[1:0]};

    // Address decode: the window is 8 bytes, registers selected by DataAdr[2].
    assign hit        = (DataAdr[31:3] == BASE_ADDR[31:3]);
    assign sel_status = (DataAdr[2] == STATUS_OFS[2]);
    assign wr_txdata  = MemWrite && hit && !sel_status;
    assign wr_status  = MemWrite && hit && sel_status;

    assign baud_last = (baud_reg == BAUD_LAST);
    // Pop from IDLE, or at the end of STOP so the next frame follows with no gap.
    assign pop = !fifo_empty &&
                 ((state_reg == IDLE) || ((state_reg == STOP) && baud_last));

    assign ovf_set = wr_txdata && fifo_full && !pop;
    assign ovf_clr = wr_status && WriteData[ST_OVF];

    mmio_uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (pop),
        .wdata (WriteData[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Set wins over a clear on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_reg <= 1'b0;
        end else if (ovf_set) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    // Transmit FSM. tx is driven from the register loaded on each bit boundary,
    // so the line value always changes exactly on a clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_rdata;
`ifdef MMIO_UART_PARITY_EN
                        par_reg   <= ^fifo_rdata;
`endif
                        baud_reg  <= '0;
                        state_reg <= START;
                        tx_reg    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_reg    <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                        tx_reg      <= shift_reg[0];
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                            state_reg <= PARITY;
                            tx_reg    <= par_reg;
`else
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
`ifdef MMIO_UART_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud_reg  <= '0;
                        state_reg <= STOP;
                        tx_reg    <= 1'b1;
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        baud_reg <= '0;
                        if (!fifo_empty) begin
                            shift_reg <= fifo_rdata;
`ifdef MMIO_UART_PARITY_EN
                            par_reg   <= ^fifo_rdata;
`endif
                            state_reg <= START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        baud_reg <= baud_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    baud_reg  <= '0;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign status_word = pack_status(state_reg != IDLE, fifo_full, fifo_empty,
                                     ovf_reg, ST_CNT_W'(fifo_count), PARITY_EN);

    // TXDATA reads as zero; only STATUS returns data.
    assign ReadData = (hit && sel_status) ? status_word : 32'd0;
    assign tx       = tx_reg;
    assign busy     = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0200_0010;
    localparam logic [31:0] STA  = 32'h0200_0014;
    localparam int          CPB  = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int          P    = 1;
    localparam logic [31:0] PAR  = 32'h200;
`else
    localparam int          P    = 0;
    localparam logic [31:0] PAR  = 32'h0;
`endif
    localparam int          FRAME = (10 + P) * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] sb[$];
    int         starts[$];

    logic       mon_act = 1'b0;
    int         mon_pos = 0;
    int         mon_bit = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] mon_exp;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Serial receiver: samples each bit in its middle and scores the byte at the stop bit.
    always @(negedge clk) begin
        if (!reset) begin
            mon_act = 1'b0;
        end else begin
            if (!mon_act) begin
                if (tx === 1'b0) begin
                    mon_act  = 1'b1;
                    mon_pos  = 0;
                    mon_byte = 8'h00;
                    starts.push_back(cyc);
                end
            end else begin
                mon_pos++;
            end
            if (mon_act && (mon_pos % CPB) == CPB / 2) begin
                mon_bit = mon_pos / CPB;
                if (mon_bit == 0) begin
                    chk("mon_start_bit", tx, 0);
                end else if (mon_bit <= 8) begin
                    mon_byte[mon_bit-1] = tx;
`ifdef MMIO_UART_PARITY_EN
                end else if (mon_bit == 9) begin
                    chk("mon_parity_bit", tx, ^mon_byte);
`endif
                end else begin
                    chk("mon_stop_bit", tx, 1);
                    chk("mon_frame_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        mon_exp = sb.pop_front();
                        chk("mon_byte", mon_byte, mon_exp);
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        MemWrite  = we;
        DataAdr   = a;
        WriteData = d;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, a, d);
        drive(1'b0, a, d);
    endtask

    task automatic read_status(input string nm, input logic [31:0] exp);
        MemWrite = 1'b0;
        DataAdr  = STA;
        @(negedge clk);
        chk(nm, ReadData, exp);
    endtask

    // Writes one byte while idle and checks the exact per-cycle tx waveform and busy release.
    task automatic check_frame(input logic [7:0] data);
        logic exp_tx;
        int   b;
        sb.push_back(data);
        store(BASE, {24'h0, data});
        for (int i = 0; i <= FRAME + 1; i++) begin
            @(negedge clk);
            b = (i - 1) / CPB;
            if (i == 0)                exp_tx = 1'b1;
            else if (b == 0)           exp_tx = 1'b0;
            else if (b <= 8)           exp_tx = data[b-1];
            else if (P == 1 && b == 9) exp_tx = ^data;
            else                       exp_tx = 1'b1;
            chk($sformatf("frame_%02h_tx_c%0d", data, i), tx, exp_tx);
            if (i == FRAME)     chk("frame_busy_last", busy, 1);
            if (i == FRAME + 1) chk("frame_busy_release", busy, 0);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (!busy && !mon_act) done = 1'b1;
        end
        chk("wait_idle_timeout", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       quiet;
        int         e6;
        int         tgt;

        vecs[0] = '{"load_status_idle",  1'b0, STA,            32'h0,         1'b1, 32'h4 | PAR};
        vecs[1] = '{"load_txdata",       1'b0, BASE,           32'h0,         1'b1, 32'h0};
        vecs[2] = '{"load_below_window", 1'b0, 32'h0200_0008,  32'h0,         1'b0, 32'h0};
        vecs[3] = '{"load_above_window", 1'b0, 32'h0200_0018,  32'h0,         1'b0, 32'h0};
        vecs[4] = '{"load_0c",           1'b0, 32'h0200_000C,  32'h0,         1'b0, 32'h0};
        vecs[5] = '{"load_status_unal",  1'b0, 32'h0200_0016,  32'h0,         1'b1, 32'h4 | PAR};
        vecs[6] = '{"load_txdata_unal",  1'b0, 32'h0200_0011,  32'h0,         1'b1, 32'h0};
        vecs[7] = '{"store_outside_18",  1'b1, 32'h0200_0018,  32'h41,        1'b0, 32'h0};
        vecs[8] = '{"store_outside_0c",  1'b1, 32'h0200_000C,  32'h42,        1'b0, 32'h0};

        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Register-access table.
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].adr, vecs[i].wd);
            @(negedge clk);
            chk({vecs[i].name, "_hit"}, hit, vecs[i].exp_hit);
            chk({vecs[i].name, "_rd"}, ReadData, vecs[i].exp_rd);
        end
        drive(1'b0, STA, 32'h0);
        read_status("status_after_outside_stores", 32'h4 | PAR);
        repeat (4) begin
            @(negedge clk);
            chk("tx_idle_after_outside_stores", tx, 1);
        end

        // Single-byte frames with exact timing.
        check_frame(8'h55);
        check_frame(8'h07);
        read_status("status_after_frames", 32'h4 | PAR);

        // Burst of six stores into a 4-deep FIFO: one dropped, overflow set.
        starts.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, BASE, 32'(i + 1));
        end
        drive(1'b0, STA, 32'h0);
        e6 = cyc;
        for (int i = 1; i <= 5; i++) sb.push_back(8'(i));
        read_status("status_after_overflow", 32'h4B | PAR);
        store(STA, 32'h8);
        read_status("status_after_ovf_clear", 32'h43 | PAR);

        // Push on the exact edge the full FIFO pops at the end of frame 1.
        tgt = e6 - 4 + FRAME;
        while (cyc != tgt - 1) begin
            @(posedge clk);
            #1;
        end
        MemWrite  = 1'b1;
        DataAdr   = BASE;
        WriteData = 32'h07;
        sb.push_back(8'h07);
        drive(1'b0, STA, 32'h0);
        read_status("status_push_pop_full", 32'h43 | PAR);

        wait_idle(8 * FRAME);
        chk("burst_frame_count", starts.size(), 6);
        for (int i = 1; i < starts.size(); i++) begin
            chk($sformatf("burst_gap_%0d", i), starts[i] - starts[i-1], FRAME);
        end
        read_status("status_after_burst", 32'h4 | PAR);

        // Reset mid-DATA of 0xA5 with two bytes queued; nothing of these should appear.
        drive(1'b1, BASE, 32'hA5);
        drive(1'b1, BASE, 32'h11);
        drive(1'b1, BASE, 32'h22);
        drive(1'b0, STA, 32'h0);
        read_status("status_two_queued", 32'h21 | PAR);
        repeat (2 * CPB) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_status", ReadData, 32'h4 | PAR);
        quiet = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        chk("abort_quiet", quiet, 1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
